instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the instruction controller: the controller decodes opcode/funct into control signals; this block turns a mnemonic plus register and immediate fields into a 32-bit instruction word.
- Encoded words are written sequentially into instruction memory. The testbench or the boot logic uses this to load programs.
- Accepts one instruction per cycle over a valid/ready handshake, registers the encoded word, and drives one write per accepted instruction.
- Tracks the load address, fill count, end-of-program and illegal-mnemonic errors.

Parameters:
- ADDR_W, 8, width of imem_addr (word address).
- DEPTH, 256, maximum words loadable per session (must be at most 2**ADDR_W).
- BASE_ADDR, 0, word address of the first instruction written after start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a load session at BASE_ADDR.
- finish  in  1  one-cycle pulse; ends the session once the pending write drains.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept the fields this cycle.
- in_mnem  in  5  mnemonic code (table in Behaviour).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  I-type immediate / branch offset.
- in_target  in  26  J-type target.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE.
- err_illegal  out  1  sticky; set on an accepted illegal mnemonic.

Behaviour:
- Reset: the FSM goes to IDLE and every output goes to 0; imem_addr resets to BASE_ADDR.
- Mnemonic codes and encodings:
  - R-type word is {6'b000000, rs, rt, rd, shamt, funct}.
  - 0 ADD 100000, 1 SUB 100010, 2 AND 100100, 3 OR 100101, 4 NOR 100111, 5 XOR 100110, 6 SLT 101010, 7 SGT 110000: shamt forced to 0.
  - 8 JR: only rs is used; rt, rd and shamt forced to 0; funct 001000.
  - 9 SLL 000000, 10 SRL 000010: rs forced to 0; shamt taken from in_shamt.
  - I-type word is {op, rs, rt, imm}: 11 XORI 001110, 12 ADDI 001000, 13 ORI 001101, 14 BEQ 000100, 15 BNE 000101, 17 LW 100011, 18 SW 101011, 19 ANDI 001100, 21 SLTI 001010.
  - J-type word is {op, target}: 16 JAL 000011, 20 J 000010.
  - 22 NOP encodes as 32'h0. Codes 23-31 are illegal.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: start moves to LOAD; count is cleared and the address is set to BASE_ADDR.
  - LOAD: in_ready = (count_accepted < DEPTH). A transfer occurs when in_valid && in_ready.
    - Legal mnemonic: the encoded word and current address are registered, and imem_we is high for exactly the next cycle.
    - The address and count then increment by 1. Throughput is 1 word/cycle; latency from accept to imem_we is 1 cycle.
    - Illegal mnemonic: the transfer is consumed, err_illegal is set, and nothing is written, so the address and count do not change.
  - finish in LOAD:
    - Go to DRAIN if a write is pending next cycle (including a transfer in the same cycle as finish); otherwise go straight to DONE.
    - in_ready is 0 from the cycle after finish onward.
  - DRAIN: issues the pending write, then goes to DONE.
  - DONE: done=1; outputs hold their final values. start re-enters LOAD and clears count and err_illegal.
- Boundaries:
  - Full: after DEPTH writes, in_ready=0 and no address wrap occurs; finish is still required to reach DONE.
  - start in LOAD: restarts the session at BASE_ADDR; any pending write still completes at its old address.
  - start and finish in the same cycle: start wins.
  - Async reset mid-session: immediate return to IDLE; the pending write is dropped and imem_we goes low at once.
  - imem_wdata and imem_addr hold their last values when imem_we=0.

Decomposition:
- Shared package holds:
  - the mnemonic enum (codes 0-22);
  - the OpCode and Func constants, identical to the controller's values;
  - the field bit positions.
- One combinational sub-module, instr_encode, maps mnemonic and fields to {word, illegal}. The FSM, counters and output registers live in the top module.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 -> one cycle later imem_we=1, imem_addr=0, imem_wdata=32'h00221820; count=1.
- Back-to-back ADDI rt=5 rs=0 imm=16'h0010, then LW rt=8 rs=29 imm=4, then SLL rd=2 rt=1 shamt=4 rs=7 -> consecutive writes:
  - addr 0 = 32'h20050010;
  - addr 1 = 32'h8FA80004;
  - addr 2 = 32'h00011100 (rs ignored).
- J target=26'h40 with finish in the same cycle -> DRAIN issues 32'h08000040, then done=1 and count=1.
- Mnemonic 25 accepted between two NOPs -> err_illegal=1; writes only to addr 0 and 1 (both 32'h0); count=2.
- DEPTH=4 with in_valid held high for 6 words -> exactly 4 writes (addr 0-3), then in_ready=0 and imem_addr never reaches 4.
- rst asserted the cycle after an accept -> imem_we never pulses; all outputs 0 and the FSM in IDLE; a subsequent start resumes at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Purpose: shared mnemonic codes, opcode/funct values and field layout for the instruction encoder/loader.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package instr_encoder_loader_pkg;

  // Mnemonic codes presented on in_mnem; 23-31 are illegal.
  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
    MN_NOR  = 5'd4,  MN_XOR  = 5'd5,  MN_SLT  = 5'd6,  MN_SGT  = 5'd7,
    MN_JR   = 5'd8,  MN_SLL  = 5'd9,  MN_SRL  = 5'd10, MN_XORI = 5'd11,
    MN_ADDI = 5'd12, MN_ORI  = 5'd13, MN_BEQ  = 5'd14, MN_BNE  = 5'd15,
    MN_JAL  = 5'd16, MN_LW   = 5'd17, MN_SW   = 5'd18, MN_ANDI = 5'd19,
    MN_J    = 5'd20, MN_SLTI = 5'd21, MN_NOP  = 5'd22
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Opcodes, matching the controller's decode table.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct values.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SGT = 6'b110000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // Field LSB positions inside the 32-bit word.
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  // Raw instruction fields as presented by the loader's producer.
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } fields_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = OP_RTYPE;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[RD_LSB +: 5] = rd;
    w[SH_LSB +: 5] = shamt;
    w[5:0]         = funct;
    return w;
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[15:0]        = imm;
    return w;
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[25:0]        = target;
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encode.sv
// Purpose: maps a mnemonic plus raw fields to a 32-bit instruction word and an illegal flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to use the result.
// Ports: mnem (5b code), fields (packed rs/rt/rd/shamt/imm/target), word (encoded), illegal (code 23-31).
module instr_encode
  import instr_encoder_loader_pkg::*;
(
  input  logic [4:0]  mnem,
  input  fields_t     fields,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      // Three-register ALU ops never carry a shift amount.
      MN_ADD:  word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_ADD);
      MN_SUB:  word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_SUB);
      MN_AND:  word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_AND);
      MN_OR:   word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_OR);
      MN_NOR:  word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_NOR);
      MN_XOR:  word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_XOR);
      MN_SLT:  word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_SLT);
      MN_SGT:  word = r_word(fields.rs, fields.rt, fields.rd, 5'd0, FN_SGT);
      MN_JR:   word = r_word(fields.rs, 5'd0, 5'd0, 5'd0, FN_JR);
      // Shifts take their source from rt; rs is not part of the encoding.
      MN_SLL:  word = r_word(5'd0, fields.rt, fields.rd, fields.shamt, FN_SLL);
      MN_SRL:  word = r_word(5'd0, fields.rt, fields.rd, fields.shamt, FN_SRL);
      MN_XORI: word = i_word(OP_XORI, fields.rs, fields.rt, fields.imm);
      MN_ADDI: word = i_word(OP_ADDI, fields.rs, fields.rt, fields.imm);
      MN_ORI:  word = i_word(OP_ORI,  fields.rs, fields.rt, fields.imm);
      MN_BEQ:  word = i_word(OP_BEQ,  fields.rs, fields.rt, fields.imm);
      MN_BNE:  word = i_word(OP_BNE,  fields.rs, fields.rt, fields.imm);
      MN_LW:   word = i_word(OP_LW,   fields.rs, fields.rt, fields.imm);
      MN_SW:   word = i_word(OP_SW,   fields.rs, fields.rt, fields.imm);
      MN_ANDI: word = i_word(OP_ANDI, fields.rs, fields.rt, fields.imm);
      MN_SLTI: word = i_word(OP_SLTI, fields.rs, fields.rt, fields.imm);
      MN_JAL:  word = j_word(OP_JAL, fields.target);
      MN_J:    word = j_word(OP_J,   fields.target);
      MN_NOP:  word = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Purpose: encodes one instruction per accepted transfer and writes it sequentially into instruction memory.
// Latency: 1 cycle from accept (in_valid && in_ready) to imem_we; sustained 1 word/cycle.
// Backpressure: in_ready low outside LOAD, when DEPTH words are written, or while start is asserted.
// Ports: start/finish session pulses; in_* instruction fields with valid/ready; imem_we/addr/wdata write port;
//        count (words written), busy (LOAD/DRAIN), done (DONE), err_illegal (sticky illegal mnemonic).
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  state_e      state;
  fields_t     fields;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        xfer;
  logic        xfer_write;

  assign fields = '{rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                    imm: in_imm, target: in_target};

  instr_encode u_encode (
    .mnem    (in_mnem),
    .fields  (fields),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // start has priority over any transfer, so hold off acceptance in that cycle
  // rather than silently discarding a handshake that the restart would clear.
  // Count only advances on real writes, so it doubles as the accepted-word count.
  assign in_ready   = (state == ST_LOAD) && !start && (count < (ADDR_W+1)'(DEPTH));
  assign xfer       = in_valid && in_ready;
  assign xfer_write = xfer && !enc_illegal;

  assign busy = (state == ST_LOAD) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      imem_we     <= 1'b0;
      imem_addr   <= ADDR_W'(BASE_ADDR);
      imem_wdata  <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      // Write strobe lasts exactly the cycle after an accept.
      imem_we <= 1'b0;
      if (start) begin
        // A write registered last cycle is already on the bus, so it completes at its old address.
        state       <= ST_LOAD;
        count       <= '0;
        err_illegal <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_LOAD: begin
            if (xfer) begin
              if (enc_illegal) begin
                err_illegal <= 1'b1;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
                imem_wdata <= enc_word;
                count      <= count + (ADDR_W+1)'(1);
              end
            end
            if (finish) begin
              state <= xfer_write ? ST_DRAIN : ST_DONE;
            end
          end
          ST_DRAIN: state <= ST_DONE;
          ST_DONE:  ;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
